// File: rtl/aes_pkg.sv
// Shared AES pipeline constants and the output serializer state encoding.
package aes_pkg;

  localparam int unsigned DATA_LEN        = 128;
  localparam int unsigned WORD_LEN        = 32;
  localparam int unsigned WORDS_PER_BLOCK = DATA_LEN / WORD_LEN;
  localparam int unsigned FIFO_DEPTH      = 4;
  localparam int unsigned DROP_CNT_W      = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/aes_block_fifo.sv
// Single-clock block FIFO; exposes the head block and the one behind it so the
// serializer can preload the next word into its output register.
module aes_block_fifo #(
  parameter int unsigned DATA_LEN   = 128,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_wr_en,
  input  logic                          i_rd_en,
  input  logic [DATA_LEN-1:0]           i_wr_data,
  output logic [DATA_LEN-1:0]           o_head_c,
  output logic [DATA_LEN-1:0]           o_head_nxt_c,
  output logic                          o_full_c,
  output logic                          o_empty_c,
  output logic [$clog2(FIFO_DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_LEN-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                w_wr;
  logic                w_rd;

  always_comb begin
    o_full_c     = (r_count == CNT_W'(FIFO_DEPTH));
    o_empty_c    = (r_count == '0);
    w_rd         = i_rd_en & ~o_empty_c;
    w_wr         = i_wr_en & (~o_full_c | w_rd);
    o_head_c     = r_mem[r_rd_ptr];
    o_head_nxt_c = r_mem[r_rd_ptr + PTR_W'(1)];
    o_count      = r_count;
  end

  // Storage array carries no reset; occupancy tracking guards every read.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/aes_out_serializer.sv
// Buffers AES ciphertext blocks and streams them MS-word first over valid/ready.
// Optional AES_OUT_DROP_CNT_EN adds a saturating dropped-block counter port.
module aes_out_serializer
  import aes_pkg::*;
#(
  parameter int unsigned DATA_LEN   = aes_pkg::DATA_LEN,
  parameter int unsigned WORD_LEN   = aes_pkg::WORD_LEN,
  parameter int unsigned FIFO_DEPTH = aes_pkg::FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                data_valid_in,
  input  logic [DATA_LEN-1:0] cipher_text,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [WORD_LEN-1:0] m_data,
  output logic                m_last,
  output logic                overflow
`ifdef AES_OUT_DROP_CNT_EN
  ,
  output logic [15:0]         drop_count
`endif
);

  localparam int unsigned WPB    = DATA_LEN / WORD_LEN;
  localparam int unsigned WCNT_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

  ser_state_e          r_state;
  ser_state_e          w_state_nxt;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [WCNT_W-1:0]   w_wcnt_nxt;
  logic [WCNT_W-1:0]   w_sel;
  logic                r_m_valid;
  logic                r_m_last;
  logic [WORD_LEN-1:0] r_m_data;
  logic                r_overflow;
  logic                w_valid_nxt;
  logic                w_last_nxt;
  logic [WORD_LEN-1:0] w_data_nxt;
  logic                w_hs;
  logic                w_pop;
  logic                w_wr;
  logic                w_drop;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [DATA_LEN-1:0] w_head_nxt;
  logic [DATA_LEN-1:0] w_fifo_head;
  logic [DATA_LEN-1:0] w_fifo_head_nxt;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;

  aes_block_fifo #(
    .DATA_LEN   (DATA_LEN),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (reset),
    .i_wr_en      (w_wr),
    .i_rd_en      (w_pop),
    .i_wr_data    (cipher_text),
    .o_head_c     (w_fifo_head),
    .o_head_nxt_c (w_fifo_head_nxt),
    .o_full_c     (w_full),
    .o_empty_c    (w_empty),
    .o_count      (w_count)
  );

  // Next state and next output word; the block that will be head after this
  // edge may still be in flight on cipher_text when the FIFO is (nearly) empty.
  always_comb begin
    w_hs        = r_m_valid & m_ready;
    w_pop       = w_hs & r_m_last;
    w_wr        = data_valid_in & (~w_full | w_pop);
    w_drop      = data_valid_in & ~w_wr;
    w_cnt_nxt   = w_count + CNT_W'(w_wr) - CNT_W'(w_pop);
    w_wcnt_nxt  = r_wcnt;
    w_state_nxt = r_state;
    w_head_nxt  = w_fifo_head;

    if (w_hs) w_wcnt_nxt = w_pop ? '0 : r_wcnt + WCNT_W'(1);

    if (w_pop) w_head_nxt = (w_count > CNT_W'(1)) ? w_fifo_head_nxt : cipher_text;
    else       w_head_nxt = w_empty ? cipher_text : w_fifo_head;

    case (r_state)
      IDLE:    if (w_cnt_nxt != '0) w_state_nxt = SEND;
      SEND:    if (w_cnt_nxt == '0) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    w_valid_nxt = (w_state_nxt == SEND);
    w_sel       = WCNT_W'(WPB - 1) - w_wcnt_nxt;
    w_data_nxt  = w_valid_nxt ? w_head_nxt[w_sel*WORD_LEN +: WORD_LEN] : '0;
    w_last_nxt  = w_valid_nxt & (w_wcnt_nxt == WCNT_W'(WPB - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_wcnt     <= '0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_m_data   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_m_valid  <= w_valid_nxt;
      r_m_last   <= w_last_nxt;
      r_m_data   <= w_data_nxt;
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign m_valid  = r_m_valid;
  assign m_last   = r_m_last;
  assign m_data   = r_m_data;
  assign overflow = r_overflow;

`ifdef AES_OUT_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                         r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != {DROP_CNT_W{1'b1}})) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
  end

  assign drop_count = r_drop_cnt;
`endif

endmodule

// File: tb/tb_aes_out_serializer.sv
// Scoreboard bench for aes_out_serializer: stimulus queues expected words and
// status checks, a negedge monitor pops and compares them.
module tb_aes_out_serializer;

  logic         clk = 1'b0;
  logic         reset;
  logic         data_valid_in;
  logic [127:0] cipher_text;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_data;
  logic         m_last;
  logic         overflow;
`ifdef AES_OUT_DROP_CNT_EN
  logic [15:0]  drop_count;
`endif

  always #5 clk = ~clk;

  aes_out_serializer dut (
    .clk           (clk),
    .reset         (reset),
    .data_valid_in (data_valid_in),
    .cipher_text   (cipher_text),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .overflow      (overflow)
`ifdef AES_OUT_DROP_CNT_EN
    ,
    .drop_count    (drop_count)
`endif
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } word_t;

  // kind: 0 = m_valid, 1 = overflow/drop_count, 2 = scoreboard drained, 3 = reset values
  typedef struct {
    int          kind;
    int          tag;
    logic        exp_valid;
    logic        exp_ovf;
    logic [15:0] exp_drop;
  } stat_t;

  word_t exp_q[$];
  stat_t stat_q[$];
  int    checks = 0;
  int    errors = 0;

  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;
  logic        prev_last  = 1'b0;

  always @(negedge clk) begin
    stat_t st;
    word_t w;
    while (stat_q.size() > 0) begin
      st = stat_q.pop_front();
      checks++;
      case (st.kind)
        0: if (m_valid !== st.exp_valid) begin
             errors++;
             $display("FAIL valid tag=%0d got=%b want=%b", st.tag, m_valid, st.exp_valid);
           end
        1: begin
             if (overflow !== st.exp_ovf) begin
               errors++;
               $display("FAIL overflow tag=%0d got=%b want=%b", st.tag, overflow, st.exp_ovf);
             end
`ifdef AES_OUT_DROP_CNT_EN
             checks++;
             if (drop_count !== st.exp_drop) begin
               errors++;
               $display("FAIL drop_count tag=%0d got=%0d want=%0d", st.tag, drop_count, st.exp_drop);
             end
`endif
           end
        2: if (exp_q.size() != 0) begin
             errors++;
             $display("FAIL drain tag=%0d outstanding=%0d want=0", st.tag, exp_q.size());
           end
        default: begin
             if ({m_valid, m_last, m_data, overflow} !== 35'd0) begin
               errors++;
               $display("FAIL reset_vals tag=%0d got v=%b l=%b d=%h o=%b want all 0",
                        st.tag, m_valid, m_last, m_data, overflow);
             end
`ifdef AES_OUT_DROP_CNT_EN
             checks++;
             if (drop_count !== 16'd0) begin
               errors++;
               $display("FAIL reset_drop tag=%0d got=%0d want=0", st.tag, drop_count);
             end
`endif
           end
      endcase
    end

    if (reset && prev_stall) begin
      checks++;
      if ({m_valid, m_last, m_data} !== {1'b1, prev_last, prev_data}) begin
        errors++;
        $display("FAIL stable got v=%b l=%b d=%h want v=1 l=%b d=%h",
                 m_valid, m_last, m_data, prev_last, prev_data);
      end
    end

    if (reset && m_valid && m_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_unexpected got d=%h l=%b want none", m_data, m_last);
      end else begin
        w = exp_q.pop_front();
        if ({m_data, m_last} !== {w.data, w.last}) begin
          errors++;
          $display("FAIL word got d=%h l=%b want d=%h l=%b", m_data, m_last, w.data, w.last);
        end
      end
    end

    prev_stall = reset && m_valid && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_words(input logic [127:0] d);
    for (int k = 0; k < 4; k++)
      exp_q.push_back('{data: d[127-32*k -: 32], last: (k == 3)});
  endtask

  task automatic push_stat(input int kind, input int tag, input logic v,
                           input logic o, input logic [15:0] dr);
    stat_q.push_back('{kind: kind, tag: tag, exp_valid: v, exp_ovf: o, exp_drop: dr});
  endtask

  task automatic drain(input int tag);
    for (int i = 0; i < 80 && exp_q.size() > 0; i++) tick();
    tick();
    push_stat(2, tag, 1'b0, 1'b0, 16'd0);
    tick();
  endtask

  localparam logic [127:0] BLK_SPEC = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] BLK_B2   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] BLK_F    = 128'hf0f0f0f10f0f0f0ea5a5a5a55a5a5a5a;
  localparam logic [127:0] BLK_G    = 128'hdeadbeefcafebabe0123456789abcdef;
  localparam logic [127:0] BLK_H    = 128'h13579bdf2468ace0fedcba9876543210;

  initial begin
    logic [127:0] blk [5];
    logic         rp  [7];
    blk[0] = 128'ha0a0a0a0a1a1a1a1a2a2a2a2a3a3a3a3;
    blk[1] = 128'hb0b0b0b0b1b1b1b1b2b2b2b2b3b3b3b3;
    blk[2] = 128'hc0c0c0c0c1c1c1c1c2c2c2c2c3c3c3c3;
    blk[3] = 128'hd0d0d0d0d1d1d1d1d2d2d2d2d3d3d3d3;
    blk[4] = 128'he0e0e0e0e1e1e1e1e2e2e2e2e3e3e3e3;
    rp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    reset = 1'b0; data_valid_in = 1'b0; m_ready = 1'b0; cipher_text = '0;
    push_stat(3, 0, 1'b0, 1'b0, 16'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // Single block followed back-to-back by a second, m_ready held high.
    m_ready = 1'b1;
    data_valid_in = 1'b1; cipher_text = BLK_SPEC;
    exp_q.push_back('{data: 32'h8ea2b7ca, last: 1'b0});
    exp_q.push_back('{data: 32'h516745bf, last: 1'b0});
    exp_q.push_back('{data: 32'heafc4990, last: 1'b0});
    exp_q.push_back('{data: 32'h4b496089, last: 1'b1});
    tick();
    cipher_text = BLK_B2;
    push_words(BLK_B2);
    push_stat(0, 10, 1'b1, 1'b0, 16'd0);
    tick();
    data_valid_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      push_stat(0, 11 + i, 1'b1, 1'b0, 16'd0);
      tick();
    end
    push_stat(0, 18, 1'b0, 1'b0, 16'd0);
    drain(19);

    // Back-pressure pattern on one block.
    m_ready = 1'b0;
    data_valid_in = 1'b1; cipher_text = BLK_SPEC;
    push_words(BLK_SPEC);
    tick();
    data_valid_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      m_ready = rp[i];
      tick();
    end
    m_ready = 1'b0;
    push_stat(0, 20, 1'b0, 1'b0, 16'd0);
    drain(21);

    // Full FIFO: new block arrives on the cycle the head's last word pops.
    for (int i = 0; i < 4; i++) begin
      data_valid_in = 1'b1; cipher_text = blk[i];
      push_words(blk[i]);
      tick();
    end
    data_valid_in = 1'b0;
    m_ready = 1'b1;
    tick(); tick(); tick();
    data_valid_in = 1'b1; cipher_text = BLK_F;
    push_words(BLK_F);
    tick();
    data_valid_in = 1'b0;
    push_stat(1, 30, 1'b0, 1'b0, 16'd0);
    drain(31);

    // Five blocks with the consumer stalled: the fifth is dropped.
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data_valid_in = 1'b1; cipher_text = blk[i];
      if (i < 4) push_words(blk[i]);
      tick();
      if (i == 3) push_stat(1, 40, 1'b0, 1'b0, 16'd0);
    end
    data_valid_in = 1'b0;
    push_stat(1, 41, 1'b0, 1'b1, 16'd1);
    tick();
    m_ready = 1'b1;
    drain(42);
    push_stat(1, 43, 1'b0, 1'b1, 16'd1);
    tick();

    // Reset after word 1 of a block; stale words must never appear.
    m_ready = 1'b0;
    data_valid_in = 1'b1; cipher_text = BLK_G;
    push_words(BLK_G);
    tick();
    data_valid_in = 1'b0;
    m_ready = 1'b1;
    tick(); tick();
    m_ready = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    push_stat(3, 50, 1'b0, 1'b0, 16'd0);
    tick(); tick();
    reset = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    push_stat(0, 51, 1'b0, 1'b0, 16'd0);
    push_stat(1, 52, 1'b0, 1'b0, 16'd0);
    tick();
    data_valid_in = 1'b1; cipher_text = BLK_H;
    push_words(BLK_H);
    tick();
    data_valid_in = 1'b0;
    drain(53);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_out_serializer.md
# aes_out_serializer

Downstream stage of the AES-256 encryption pipeline. Takes each 128-bit ciphertext block from the core's `data_valid_out`/`cipher_text` outputs and buffers it in a small block FIFO. It streams each block as four 32-bit words over a valid/ready interface. The core cannot stall, so this block absorbs back-pressure and flags blocks it has to drop.

## Interface
Parameters:
- `DATA_LEN`, 128, ciphertext block width.
- `WORD_LEN`, 32, output word width; `DATA_LEN` must be a multiple of it.
- `FIFO_DEPTH`, 4, blocks buffered; power of two, ≥2.

Ports (one clock; reset is asynchronous, active-low):
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `data_valid_in`  in  1  ciphertext block present this cycle; connects to core `data_valid_out`.
- `cipher_text`  in  `DATA_LEN`  ciphertext block.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  consumer accepts word.
- `m_data`  out  `WORD_LEN`  output word.
- `m_last`  out  1  final word of the block.
- `overflow`  out  1  sticky flag: a block was dropped.
- `drop_count`  out  16  dropped-block count; exists only with `AES_OUT_DROP_CNT_EN`.

## Operation
- **Write.** A block is written when `data_valid_in`=1 and either the FIFO is not full or a pop occurs in the same cycle.
  - Otherwise the block is dropped and `overflow` is set to 1.
  - `overflow` stays set until reset.
- **Pop.** A pop occurs when `m_valid & m_ready & m_last`.
- **Word order.** Most-significant word first: word k = head[`DATA_LEN`-1-k·`WORD_LEN` -: `WORD_LEN`], k = 0..3.
- **FSM states:**
  - IDLE: FIFO empty, `m_valid`=0. Moves to SEND when the count becomes nonzero.
  - SEND: `m_valid`=1 and `m_data` = word `wcnt` of the head block.
    - On `m_valid & m_ready`, `wcnt` increments.
    - At `wcnt`=3 the handshake pops the block and resets `wcnt` to 0.
    - After the pop, the FSM stays in SEND if the post-pop count is >0, otherwise returns to IDLE.
- **Stability.** `m_data`, `m_last` and `m_valid` must not change while `m_valid`=1 and `m_ready`=0.
- **Pointers.** Read and write pointers are `$clog2(FIFO_DEPTH)` bits and wrap modulo `FIFO_DEPTH`. Occupancy count is `$clog2(FIFO_DEPTH)+1` bits.

## Timing
- **Reset values** (`reset`=0, asynchronous):
  - `m_valid`=0, `m_last`=0, `m_data`=0, `overflow`=0, `drop_count`=0.
  - Pointers, count and `wcnt` cleared; FSM in IDLE.
  - Reset during a block discards all buffered data.
- **Latency.** A block written at edge N into an empty FIFO gives `m_valid`=1 with word 0 after edge N.
  - With `m_ready` held at 1, the 4 words occupy 4 consecutive cycles.
  - Back-to-back blocks stream with no bubble.
- **Full.** Full is count == `FIFO_DEPTH`. A write plus a pop in the same cycle leaves the count unchanged.
- **Empty.** Empty is count == 0; no pop can occur while empty.
- **Throughput.** Sustained input of one block per cycle overflows after `FIFO_DEPTH`+1 blocks.

## Configuration
- `AES_OUT_DROP_CNT_EN` defined:
  - Port `drop_count[15:0]` exists.
  - It increments on every dropped block and saturates at 16'hFFFF.
- `AES_OUT_DROP_CNT_EN` undefined:
  - The port and its counter are absent.
  - `overflow` behaviour is identical in both builds.

## Structure
- Shared package `aes_pkg`:
  - `DATA_LEN`, `WORD_LEN`, `WORDS_PER_BLOCK` (= `DATA_LEN`/`WORD_LEN`).
  - Serializer state enum {IDLE, SEND}.
- Sub-module `aes_block_fifo`:
  - Single-clock `DATA_LEN`-wide FIFO.
  - Signals: wr_en, rd_en, head data, full, empty, count.
- The top level holds the FSM, `wcnt`, the overflow logic and the optional drop counter.

## Test plan
1. **Single block.** Reset, then one pulse of `data_valid_in` with `cipher_text`=128'h8ea2b7ca516745bfeafc49904b496089 and `m_ready`=1.
   - Expect `m_data` = 8ea2b7ca, 516745bf, eafc4990, 4b496089 on 4 consecutive cycles, with `m_last` only on the 4th.
2. **Back-pressure.** Same block, with `m_ready` toggled 1,0,0,1,0,1,1.
   - Words are held stable during stalls; exactly 4 handshakes complete, in order.
3. **Overflow.** With `m_ready`=0, send 5 consecutive blocks A..E.
   - Blocks A–D are buffered and E is dropped.
   - `overflow`=1, and `drop_count`=1 when the macro is enabled.
   - Releasing `m_ready` outputs A,B,C,D only.
4. **Write on pop.** FIFO full and the last word of the head accepted in the same cycle as a new block F.
   - F is accepted, the count stays at 4, and no overflow occurs.
5. **Reset mid-stream.** Assert `reset` after word 1 of a block.
   - `m_valid`=0 immediately; after release, no stale words are emitted.
   - A new block then streams correctly from word 0.
